// File: rtl/riscv_ckpt_checker.sv
// Checkpoint monitor: compares the core's NUM_INST/OUTPUT_PORT against a programmable ordered table.
// Latency: all outputs are registered and show the decision one edge after the deciding inputs.
// No backpressure: the core is observed passively, one checkpoint is evaluated per cycle.
module riscv_ckpt_checker #(
    parameter int NUM_CKPT = 17,
    parameter int IW       = 32,
    parameter int DW       = 32,
    parameter int CW       = 32,
    parameter int TIMEOUT  = 1000000,
    localparam int IDX_W   = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1,
    localparam int CNT_W   = $clog2(NUM_CKPT + 1)
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             CFG_WE,
    input  logic [IDX_W-1:0] CFG_IDX,
    input  logic [IW-1:0]    CFG_NUM_INST,
    input  logic [DW-1:0]    CFG_ANS,
    input  logic [DW-1:0]    CFG_MASK,
    input  logic [CNT_W-1:0] CFG_CNT,
    input  logic             START,
    input  logic             CLEAR,
    input  logic [IW-1:0]    NUM_INST,
    input  logic [DW-1:0]    OUTPUT_PORT,
    input  logic             HALT,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [2:0]       FAIL_CODE,
    output logic [IDX_W-1:0] FAIL_IDX,
    output logic [DW-1:0]    FAIL_VALUE,
    output logic [CW-1:0]    CYCLE
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PASS = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    localparam logic [2:0] C_MISMATCH   = 3'd1;
    localparam logic [2:0] C_SKIPPED    = 3'd2;
    localparam logic [2:0] C_INCOMPLETE = 3'd3;
    localparam logic [2:0] C_TIMEOUT    = 3'd4;

    logic [1:0]       r_state;
    logic [IW-1:0]    r_tab_num  [NUM_CKPT];
    logic [DW-1:0]    r_tab_ans  [NUM_CKPT];
    logic [DW-1:0]    r_tab_mask [NUM_CKPT];
    logic [CNT_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [CW-1:0]    r_cycle;
    logic [2:0]       r_fail_code;
    logic [IDX_W-1:0] r_fail_idx;
    logic [DW-1:0]    r_fail_value;

    logic             w_in_range;
    logic [IDX_W-1:0] w_sel;
    logic             w_eq;
    logic             w_bits_ok;
    logic             w_match;
    logic             w_mism;
    logic             w_skip;
    logic [CNT_W-1:0] w_ptr_nxt;
    logic             w_timeout;
    logic             w_cfg_ok;
    logic [CNT_W-1:0] w_cnt_sat;

    assign w_in_range = (r_ptr < r_cnt);
    // Clamp the read index so a finished table never addresses past the array.
    assign w_sel      = w_in_range ? r_ptr[IDX_W-1:0] : '0;
    assign w_eq       = (NUM_INST == r_tab_num[w_sel]);
    assign w_bits_ok  = (((OUTPUT_PORT ^ r_tab_ans[w_sel]) & r_tab_mask[w_sel]) == '0);
    assign w_match    = w_in_range && w_eq && w_bits_ok;
    assign w_mism     = w_in_range && w_eq && !w_bits_ok;
    assign w_skip     = w_in_range && (NUM_INST > r_tab_num[w_sel]);
    assign w_ptr_nxt  = r_ptr + CNT_W'(w_match);
    assign w_timeout  = ((r_cycle + CW'(1)) == CW'(TIMEOUT));
    assign w_cfg_ok   = ({1'b0, CFG_IDX} < (IDX_W + 1)'(NUM_CKPT));
    assign w_cnt_sat  = (CFG_CNT > CNT_W'(NUM_CKPT)) ? CNT_W'(NUM_CKPT) : CFG_CNT;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                r_tab_num[i]  <= '0;
                r_tab_ans[i]  <= '0;
                r_tab_mask[i] <= '0;
            end
        end else if ((r_state == S_IDLE) && CFG_WE && w_cfg_ok) begin
            r_tab_num[CFG_IDX]  <= CFG_NUM_INST;
            r_tab_ans[CFG_IDX]  <= CFG_ANS;
            r_tab_mask[CFG_IDX] <= CFG_MASK;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_cycle      <= '0;
            r_fail_code  <= '0;
            r_fail_idx   <= '0;
            r_fail_value <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!CLEAR && START) begin
                        r_state      <= S_RUN;
                        r_cnt        <= w_cnt_sat;
                        r_ptr        <= '0;
                        r_cycle      <= '0;
                        r_fail_code  <= '0;
                        r_fail_idx   <= '0;
                        r_fail_value <= '0;
                    end
                end
                S_RUN: begin
                    if (CLEAR) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_ptr <= w_ptr_nxt;
                        if (w_mism || w_skip) begin
                            r_state      <= S_FAIL;
                            r_fail_code  <= w_mism ? C_MISMATCH : C_SKIPPED;
                            r_fail_idx   <= r_ptr[IDX_W-1:0];
                            r_fail_value <= OUTPUT_PORT;
                        end else if (HALT) begin
                            if (w_ptr_nxt == r_cnt) begin
                                r_state <= S_PASS;
                            end else begin
                                r_state      <= S_FAIL;
                                r_fail_code  <= C_INCOMPLETE;
                                r_fail_idx   <= w_ptr_nxt[IDX_W-1:0];
                                r_fail_value <= OUTPUT_PORT;
                            end
                        end else if (w_timeout) begin
                            r_state      <= S_FAIL;
                            r_fail_code  <= C_TIMEOUT;
                            r_fail_idx   <= r_ptr[IDX_W-1:0];
                            r_fail_value <= OUTPUT_PORT;
                        end
                        // The timeout edge leaves CYCLE at TIMEOUT-1; every other RUN edge counts.
                        if (w_mism || w_skip || HALT || !w_timeout) begin
                            r_cycle <= r_cycle + CW'(1);
                        end
                    end
                end
                default: begin
                    if (CLEAR) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign BUSY       = (r_state == S_RUN);
    assign DONE       = (r_state == S_PASS) || (r_state == S_FAIL);
    assign PASS       = (r_state == S_PASS);
    assign FAIL_CODE  = r_fail_code;
    assign FAIL_IDX   = r_fail_idx;
    assign FAIL_VALUE = r_fail_value;
    assign CYCLE      = r_cycle;

endmodule

// File: doc/riscv_ckpt_checker.md
Name: riscv_ckpt_checker

Overview:
- Synthesizable checkpoint monitor for the RISCV core.
- Holds a programmable table of (instruction-count, expected OUTPUT_PORT, bit mask) checkpoints.
- Checks them in order against the core's NUM_INST and OUTPUT_PORT while the program runs, then reports pass/fail, the failure reason, and the cycle count.
- Sits beside RISCV_TOP in benches and on FPGA builds in place of simulation-only checking.

Parameters:
- NUM_CKPT, 17, table depth (≥1); IDX_W = clog2(NUM_CKPT), CNT_W = clog2(NUM_CKPT+1)
- IW, 32, width of NUM_INST
- DW, 32, width of OUTPUT_PORT, answers and masks
- CW, 32, cycle counter width
- TIMEOUT, 1000000, RUN cycles before forced timeout fail (must be < 2^CW)

Ports:
- CLK  in  1  clock, all state on rising edge
- RSTn  in  1  asynchronous active-low reset
- CFG_WE  in  1  write table entry CFG_IDX (accepted only in IDLE)
- CFG_IDX  in  IDX_W  entry index; writes with CFG_IDX ≥ NUM_CKPT ignored
- CFG_NUM_INST  in  IW  checkpoint instruction count
- CFG_ANS  in  DW  expected value
- CFG_MASK  in  DW  compare mask, 1 = bit checked
- CFG_CNT  in  CNT_W  number of valid entries, sampled on START
- START  in  1  IDLE→RUN
- CLEAR  in  1  any state→IDLE; table contents kept
- NUM_INST  in  IW  core retired-instruction count
- OUTPUT_PORT  in  DW  core output port
- HALT  in  1  core halt
- BUSY  out  1  high in RUN
- DONE  out  1  high in PASS or FAIL
- PASS  out  1  high in PASS
- FAIL_CODE  out  3  0 none, 1 mismatch, 2 skipped, 3 incomplete, 4 timeout
- FAIL_IDX  out  IDX_W  entry pointer at failure
- FAIL_VALUE  out  DW  OUTPUT_PORT sampled at failure
- CYCLE  out  CW  RUN cycle count

Behaviour:
- Reset: state IDLE, table entries all zero, ptr=0, cnt=0, CYCLE=0. All outputs 0.
- All outputs are registered and reflect state after the deciding edge, i.e. a one-cycle latency from the input condition.
- IDLE: CFG_WE writes the entry. START latches CFG_CNT (saturated to NUM_CKPT), ptr=0, CYCLE=0, FAIL_*=0, then goes to RUN. CFG_WE and START in the same cycle: the write lands first, then START.
- RUN, each edge, in priority order:
  - (a) CLEAR.
  - (b) Checkpoint at ptr, if ptr<cnt:
    - NUM_INST == entry.num_inst and (OUTPUT_PORT^entry.ans)&entry.mask == 0 → ptr+1.
    - Equal count but masked mismatch → FAIL, code 1.
    - NUM_INST > entry.num_inst (unsigned) → FAIL, code 2. This means the checkpoint was skipped; the table must be ascending.
  - (c) HALT: uses ptr after step (b). If ptr==cnt → PASS, else FAIL code 3. A final checkpoint matched in the same cycle as HALT yields PASS. A mismatch in the same cycle as HALT yields code 1.
  - (d) CYCLE+1 == TIMEOUT → FAIL code 4. Lowest priority.
  - Otherwise CYCLE increments.
- Only one checkpoint is evaluated per cycle. Consecutive entries with an equal count therefore fail as skipped on the next cycle, unless NUM_INST holds.
- cnt==0: no checks; HALT → PASS.
- FAIL latches FAIL_IDX=ptr and FAIL_VALUE=OUTPUT_PORT from the deciding edge.
- CYCLE freezes in PASS and FAIL.
- PASS/FAIL are sticky until CLEAR or reset. CFG_WE and START are ignored there.
- CLEAR returns to IDLE and zeroes BUSY, DONE and PASS. FAIL_CODE, FAIL_IDX, FAIL_VALUE and CYCLE are kept until the next START.
- RSTn low mid-RUN clears everything immediately, including the table.
- NUM_INST and OUTPUT_PORT are sampled only in RUN.

Test Plan:
1. Program 3 entries: (4,0x0eec,all-ones), (6,0,all-ones), (8,1,all-ones); cnt=3. Drive NUM_INST 0..8 with matching ports, HALT at 9 → PASS=1, FAIL_CODE=0, CYCLE=10.
2. Same table, OUTPUT_PORT=0x0eed at NUM_INST=4 → FAIL_CODE=1, FAIL_IDX=0, FAIL_VALUE=0x0eed. DONE rises one edge later.
3. Mask=0xFFFFFF00, ans=0x0f00, port=0x0f55 at count 0x3c → match, ptr advances. Same case with mask all-ones → code 1.
4. NUM_INST jumps 4→10 (entry 1 at 6) → FAIL_CODE=2, FAIL_IDX=1. HALT with ptr=2 of cnt=3 → FAIL_CODE=3.
5. TIMEOUT=20, no HALT → FAIL_CODE=4, CYCLE=19. Final match together with HALT on the same edge → PASS.
6. RSTn low mid-RUN → all outputs 0 asynchronously, table cleared. CLEAR then START reruns. CFG_WE in RUN has no effect on the table.
